// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt arbiter: FSM states, PC mux
// encodings, default vector layout and the vector address helper.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

  localparam logic [1:0] PC_NEXT   = 2'h0;
  localparam logic [1:0] PC_BRANCH = 2'h1;
  localparam logic [1:0] PC_JUMP   = 2'h2;
  localparam logic [1:0] PC_SAVE   = 2'h3;

  localparam logic [10:0] VECTOR_BASE_DEFAULT   = 11'h4;
  localparam logic [10:0] VECTOR_STRIDE_DEFAULT = 11'h4;

  // 11-bit modulo arithmetic; the parameters are expected to keep vectors in range.
  function automatic logic [10:0] vector_addr(input logic [10:0] base,
                                              input logic [10:0] stride,
                                              input logic [10:0] id);
    return base + stride * id;
  endfunction

endpackage

// File: rtl/irq_priority_encoder.sv
// Rotating-start priority encoder: returns the first set bit of eligible,
// searching upward (with wrap) from start. start = 0 gives lowest-index-wins.
module irq_priority_encoder
  import irq_pkg::*;
#(
  parameter int NUM_SOURCES = 4
) (
  input  logic [NUM_SOURCES-1:0]         eligible,
  input  logic [$clog2(NUM_SOURCES)-1:0] start,
  output logic [$clog2(NUM_SOURCES)-1:0] id,
  output logic                           valid
);

  localparam int ID_W = $clog2(NUM_SOURCES);

  // Walk offsets from the far end back to 0 so the nearest eligible source
  // is the last one assigned and therefore wins.
  always_comb begin
    logic [ID_W:0] idx;
    id    = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = NUM_SOURCES - 1; k >= 0; k--) begin
      idx = {1'b0, start} + (ID_W + 1)'(k);
      if (idx >= (ID_W + 1)'(NUM_SOURCES)) begin
        idx = idx - (ID_W + 1)'(NUM_SOURCES);
      end
      if (eligible[idx[ID_W-1:0]]) begin
        id    = idx[ID_W-1:0];
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_arbiter.sv
// Multi-source interrupt arbiter: edge capture, masking, priority selection and
// a one-cycle irq pulse held off until rfi. Define IRQ_ROUND_ROBIN_EN for rotating priority.
module irq_arbiter
  import irq_pkg::*;
#(
  parameter int                      NUM_SOURCES   = 4,
  parameter logic [10:0]             VECTOR_BASE   = VECTOR_BASE_DEFAULT,
  parameter logic [10:0]             VECTOR_STRIDE = VECTOR_STRIDE_DEFAULT,
  parameter logic [1:0]              PC_SAVE       = irq_pkg::PC_SAVE,
  parameter logic [NUM_SOURCES-1:0]  MASK_RESET    = '1
) (
  input  logic                           instr_clock,
  input  logic                           reset,
  input  logic [NUM_SOURCES-1:0]         irq_src,
  input  logic                           mask_we,
  input  logic [NUM_SOURCES-1:0]         mask_wdata,
  input  logic [1:0]                     pc_mux_control,
  output logic                           irq,
  output logic [$clog2(NUM_SOURCES)-1:0] irq_id,
  output logic [10:0]                    irq_vector,
  output logic                           in_service,
  output logic [NUM_SOURCES-1:0]         pending
);

  localparam int ID_W = $clog2(NUM_SOURCES);

  irq_state_t              state_reg, state_next;
  logic [NUM_SOURCES-1:0]  src_q;
  logic [NUM_SOURCES-1:0]  pending_reg, pending_next;
  logic [NUM_SOURCES-1:0]  mask_reg, mask_next;
  logic                    irq_reg, irq_next;
  logic                    in_service_reg, in_service_next;
  logic [ID_W-1:0]         irq_id_reg, irq_id_next;
  logic [NUM_SOURCES-1:0]  grant_clear;
  logic [NUM_SOURCES-1:0]  rise;
  logic [NUM_SOURCES-1:0]  eligible;
  logic [ID_W-1:0]         start_idx;
  logic [ID_W-1:0]         win_id;
  logic                    win_valid;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SOURCES; gi++) begin : g_src
      assign rise[gi]     = irq_src[gi] & ~src_q[gi];
      assign eligible[gi] = pending_reg[gi] & mask_reg[gi];
    end
  endgenerate

  irq_priority_encoder #(
    .NUM_SOURCES (NUM_SOURCES)
  ) u_prio (
    .eligible (eligible),
    .start    (start_idx),
    .id       (win_id),
    .valid    (win_valid)
  );

`ifdef IRQ_ROUND_ROBIN_EN
  logic [ID_W-1:0] last_reg, last_next;

  // Pointer resets to the top source so the very first search starts at 0.
  always_ff @(posedge instr_clock) begin
    if (reset) begin
      last_reg <= ID_W'(NUM_SOURCES - 1);
    end else begin
      last_reg <= last_next;
    end
  end

  always_comb begin
    last_next = last_reg;
    if (state_reg == IDLE && win_valid) begin
      last_next = win_id;
    end
  end

  assign start_idx = (last_reg == ID_W'(NUM_SOURCES - 1)) ? '0 : last_reg + 1'b1;
`else
  assign start_idx = '0;
`endif

  always_ff @(posedge instr_clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      src_q          <= '0;
      pending_reg    <= '0;
      mask_reg       <= MASK_RESET;
      irq_reg        <= 1'b0;
      in_service_reg <= 1'b0;
      irq_id_reg     <= '0;
    end else begin
      state_reg      <= state_next;
      src_q          <= irq_src;
      pending_reg    <= pending_next;
      mask_reg       <= mask_next;
      irq_reg        <= irq_next;
      in_service_reg <= in_service_next;
      irq_id_reg     <= irq_id_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    irq_next        = 1'b0;
    in_service_next = in_service_reg;
    irq_id_next     = irq_id_reg;
    grant_clear     = '0;
    case (state_reg)
      IDLE: begin
        if (win_valid) begin
          grant_clear[win_id] = 1'b1;
          irq_next            = 1'b1;
          in_service_next     = 1'b1;
          irq_id_next         = win_id;
          state_next          = REQUEST;
        end
      end
      // rfi is deliberately ignored here; the core cannot have returned yet.
      REQUEST: state_next = SERVICE;
      SERVICE: begin
        if (pc_mux_control == PC_SAVE) begin
          in_service_next = 1'b0;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // A fresh edge on the bit being granted survives the clear.
    pending_next = (pending_reg & ~grant_clear) | rise;
    mask_next    = mask_we ? mask_wdata : mask_reg;
  end

  assign irq        = irq_reg;
  assign in_service = in_service_reg;
  assign irq_id     = irq_id_reg;
  assign pending    = pending_reg;
  assign irq_vector = vector_addr(VECTOR_BASE, VECTOR_STRIDE, 11'(irq_id_reg));

endmodule
